// File: rtl/rv32v_write_packer.sv
// Packs SEW8/16/32 lane beats into one 4-bank line with byte enables; wr_valid 1 cycle after completion.
// Backpressure: line held in FULL with in_ready=0 until wr_ready; no bypass from input to write port.
package rv32v_write_packer_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2} vsew_t;
endpackage

module rv32v_write_packer
  import rv32v_write_packer_pkg::*;
(
  input  logic            CLK,
  input  logic            nRST,
  input  logic            in_valid,
  output logic            in_ready,
  input  word_t     [3:0] lane_dat,
  input  logic      [3:0] lane_en,
  input  vsew_t           veew,
  input  logic            in_last,
  input  logic            flush,
  output logic            wr_valid,
  input  logic            wr_ready,
  output word_t     [3:0] wr_dat,
  output logic     [15:0] wr_byte_en
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       r_beat_cnt;
  vsew_t            r_line_eew;
  logic [15:0][7:0] r_buf;
  logic [15:0]      r_be;

  logic             w_acc;
  vsew_t            w_eew;
  logic             w_done;
  logic [15:0][7:0] w_buf_nxt;
  logic [15:0]      w_be_nxt;

  assign in_ready   = (r_state != S_FULL);
  assign wr_valid   = (r_state == S_FULL);
  assign wr_dat     = r_buf;
  assign wr_byte_en = r_be;
  assign w_acc      = in_valid && in_ready;

  // The first beat of a line uses the live width; later beats use the latched one.
  assign w_eew = (r_state == S_EMPTY) ? veew : r_line_eew;

  always_comb begin
    w_done = in_last;
    case (w_eew)
      SEW8:    if (r_beat_cnt == 2'd3) w_done = 1'b1;
      SEW16:   if (r_beat_cnt[0])      w_done = 1'b1;
      default: w_done = 1'b1;
    endcase
  end

  // Byte index is {bank, byte}; each width maps lane/beat bits straight onto it.
  always_comb begin
    w_buf_nxt = r_buf;
    w_be_nxt  = r_be;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        case (w_eew)
          SEW8: begin
            w_buf_nxt[{r_beat_cnt, 2'(i)}] = lane_dat[i][7:0];
            w_be_nxt[{r_beat_cnt, 2'(i)}]  = 1'b1;
          end
          SEW16: begin
            for (int j = 0; j < 2; j++) begin
              w_buf_nxt[{r_beat_cnt[0], 2'(i), 1'(j)}] = lane_dat[i][8*j +: 8];
              w_be_nxt[{r_beat_cnt[0], 2'(i), 1'(j)}]  = 1'b1;
            end
          end
          default: begin
            for (int j = 0; j < 4; j++) begin
              w_buf_nxt[{2'(i), 2'(j)}] = lane_dat[i][8*j +: 8];
              w_be_nxt[{2'(i), 2'(j)}]  = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= S_EMPTY;
      r_beat_cnt <= 2'd0;
      r_line_eew <= SEW32;
      r_buf      <= '0;
      r_be       <= '0;
    end else begin
      case (r_state)
        S_EMPTY, S_FILL: begin
          if (w_acc) begin
            r_buf <= w_buf_nxt;
            r_be  <= w_be_nxt;
            if (r_state == S_EMPTY) r_line_eew <= veew;
            if (w_done || flush) begin
              r_state <= S_FULL;
            end else begin
              r_state    <= S_FILL;
              r_beat_cnt <= r_beat_cnt + 2'd1;
            end
          end else if (flush && r_state == S_FILL) begin
            r_state <= S_FULL;
          end
        end
        S_FULL: begin
          if (wr_ready) begin
            r_state    <= S_EMPTY;
            r_beat_cnt <= 2'd0;
            r_buf      <= '0;
            r_be       <= '0;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule
